// File: rtl/riscv_rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_rf_wr_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters and keeps a per-register busy scoreboard.
//   - Requester 0 is ALU/execute writeback.
//   - Requester 1 is load/memory writeback.
//   At most one request is granted per cycle. The granted write appears on
//   the registered write port in the following cycle. Decode reservations set
//   busy bits, and writebacks clear them. A reservation wins over a clear
//   that lands on the same register at the same edge.
//
// Configuration:
//   RISCV_RFARB_RR_EN defined   -> round-robin priority. A one-bit pointer
//                                  favours the requester that lost the last
//                                  transfer.
//   RISCV_RFARB_RR_EN undefined -> fixed priority. Requester 1 (load) always
//                                  wins, and no pointer register exists.
//
// Ports:
//   i_CLK, i_RST_N                        clock, async active-low reset
//   i_REQ{0,1}_VALID/_ADDR/_DATA          writeback requests
//   o_REQ{0,1}_READY                      combinational grants
//   i_WP_HOLD                             blocks all grants (debug access)
//   i_RSV_VALID, i_RSV_ADDR               decode reservation of a register
//   o_WREnable, o_WRR, o_WRDATA           registered register-file write port
//   o_BUSY                                scoreboard, bit n = reg n pending
// ---------------------------------------------------------------------------
module riscv_rf_wr_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DEPTH      = 1 << REG_ADDR_WIDTH
) (
  input  logic                      i_CLK,
  input  logic                      i_RST_N,
  input  logic                      i_REQ0_VALID,
  input  logic [REG_ADDR_WIDTH-1:0] i_REQ0_ADDR,
  input  logic [BUS_WIDTH-1:0]      i_REQ0_DATA,
  output logic                      o_REQ0_READY,
  input  logic                      i_REQ1_VALID,
  input  logic [REG_ADDR_WIDTH-1:0] i_REQ1_ADDR,
  input  logic [BUS_WIDTH-1:0]      i_REQ1_DATA,
  output logic                      o_REQ1_READY,
  input  logic                      i_WP_HOLD,
  input  logic                      i_RSV_VALID,
  input  logic [REG_ADDR_WIDTH-1:0] i_RSV_ADDR,
  output logic                      o_WREnable,
  output logic [REG_ADDR_WIDTH-1:0] o_WRR,
  output logic [BUS_WIDTH-1:0]      o_WRDATA,
  output logic [REG_DEPTH-1:0]      o_BUSY
);

  logic                      gnt0, gnt1, xfer;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [BUS_WIDTH-1:0]      sel_data;

  logic                      wr_en_d, wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] wrr_d, wrr_q;
  logic [BUS_WIDTH-1:0]      wrdata_d, wrdata_q;
  logic [REG_DEPTH-1:0]      busy_d, busy_q;
`ifdef RISCV_RFARB_RR_EN
  logic                      ptr_d, ptr_q;  // 0 favours requester 0
`endif

  // Grant logic: purely combinational from the VALIDs, the hold and the pointer.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_WP_HOLD) begin
`ifdef RISCV_RFARB_RR_EN
      if (i_REQ0_VALID && i_REQ1_VALID) begin
        gnt0 = !ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = i_REQ0_VALID;
        gnt1 = i_REQ1_VALID;
      end
`else
      gnt1 = i_REQ1_VALID;
      gnt0 = i_REQ0_VALID && !i_REQ1_VALID;
`endif
    end
  end

  assign xfer     = gnt0 || gnt1;
  assign sel_addr = gnt1 ? i_REQ1_ADDR : i_REQ0_ADDR;
  assign sel_data = gnt1 ? i_REQ1_DATA : i_REQ0_DATA;

  // Next-state: write port, scoreboard and priority pointer.
  always_comb begin
    wr_en_d  = 1'b0;
    wrr_d    = wrr_q;
    wrdata_d = wrdata_q;
    busy_d   = busy_q;
    if (xfer) begin
      // An x0 write is still accepted, but it never reaches the file.
      wr_en_d  = (sel_addr != '0);
      wrr_d    = sel_addr;
      wrdata_d = sel_data;
      if (sel_addr != '0) busy_d[sel_addr] = 1'b0;
    end
    // The reservation is applied after the clear, so set wins on a collision.
    if (i_RSV_VALID && (i_RSV_ADDR != '0)) busy_d[i_RSV_ADDR] = 1'b1;
    busy_d[0] = 1'b0;
`ifdef RISCV_RFARB_RR_EN
    ptr_d = ptr_q;
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      wr_en_q  <= 1'b0;
      wrr_q    <= '0;
      wrdata_q <= '0;
      busy_q   <= '0;
`ifdef RISCV_RFARB_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      wr_en_q  <= wr_en_d;
      wrr_q    <= wrr_d;
      wrdata_q <= wrdata_d;
      busy_q   <= busy_d;
`ifdef RISCV_RFARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign o_REQ0_READY = gnt0;
  assign o_REQ1_READY = gnt1;
  assign o_WREnable   = wr_en_q;
  assign o_WRR        = wrr_q;
  assign o_WRDATA     = wrdata_q;
  assign o_BUSY       = busy_q;

endmodule

// File: tb/tb_riscv_rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_rf_wr_arbiter
//
// Self-checking bench for riscv_rf_wr_arbiter. A behavioural model tracks
// three things:
//   - which requester is favoured,
//   - the last write presented to the register file,
//   - the set of registers with a write outstanding.
// Each cycle's expected grants and registered outputs are derived from the
// arbitration and scoreboard rules. Inputs change on the falling edge.
// Grants are sampled 1ns later, and registered outputs are sampled 1ns after
// the rising edge. The bench follows RISCV_RFARB_RR_EN the same way the design
// does.
// ---------------------------------------------------------------------------
module tb_riscv_rf_wr_arbiter;

  localparam int BW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [BW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          wp_hold;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic          wr_en;
  logic [AW-1:0] wrr;
  logic [BW-1:0] wrdata;
  logic [NR-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_fav;       // requester preferred when both are valid
  bit            m_wen;
  int            m_wrr;
  logic [BW-1:0] m_wrdata;
  bit            m_busy [NR];
  int            last_grant;  // -1 none, 0, 1

  riscv_rf_wr_arbiter #(.BUS_WIDTH(BW), .REG_ADDR_WIDTH(AW)) dut (
    .i_CLK        (clk),
    .i_RST_N      (rst_n),
    .i_REQ0_VALID (req0_valid),
    .i_REQ0_ADDR  (req0_addr),
    .i_REQ0_DATA  (req0_data),
    .o_REQ0_READY (req0_ready),
    .i_REQ1_VALID (req1_valid),
    .i_REQ1_ADDR  (req1_addr),
    .i_REQ1_DATA  (req1_data),
    .o_REQ1_READY (req1_ready),
    .i_WP_HOLD    (wp_hold),
    .i_RSV_VALID  (rsv_valid),
    .i_RSV_ADDR   (rsv_addr),
    .o_WREnable   (wr_en),
    .o_WRR        (wrr),
    .o_WRDATA     (wrdata),
    .o_BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_fav    = 0;
    m_wen    = 0;
    m_wrr    = 0;
    m_wrdata = '0;
    for (int i = 0; i < NR; i++) m_busy[i] = 0;
  endfunction

  function automatic logic [NR-1:0] model_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Which requester the rules say wins this cycle, or -1 if none.
  function automatic int model_grant();
    if (wp_hold) return -1;
    if (req0_valid && req1_valid) begin
`ifdef RISCV_RFARB_RR_EN
      return m_fav;
`else
      return 1;
`endif
    end
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic void idle_inputs();
    req0_valid = 0; req1_valid = 0; wp_hold = 0; rsv_valid = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    rsv_addr = '0;
  endfunction

  // One clock cycle. The task is entered just after a falling edge, with
  // inputs already driven, and it returns at the next falling edge.
  task automatic step(input string tag);
    int            g;
    int            a;
    logic [BW-1:0] d;
    #1;
    g = model_grant();
    n_checks++;
    if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
      n_fail++;
      $display("FAIL %s ready: got r0=%b r1=%b, want r0=%b r1=%b", tag,
               req0_ready, req1_ready, g == 0, g == 1);
    end
    last_grant = g;
    @(posedge clk);
    if (g >= 0) begin
      a        = (g == 0) ? int'(req0_addr) : int'(req1_addr);
      d        = (g == 0) ? req0_data : req1_data;
      m_wen    = (a != 0);
      m_wrr    = a;
      m_wrdata = d;
      if (a != 0) m_busy[a] = 0;
      m_fav    = 1 - g;
    end else begin
      m_wen = 0;
    end
    if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
    #1;
    n_checks++;
    if (wr_en !== m_wen || wrr !== AW'(m_wrr) || wrdata !== m_wrdata) begin
      n_fail++;
      $display("FAIL %s wport: got en=%b a=%0d d=%h, want en=%b a=%0d d=%h",
               tag, wr_en, wrr, wrdata, m_wen, m_wrr, m_wrdata);
    end
    n_checks++;
    if (busy !== model_busy_vec()) begin
      n_fail++;
      $display("FAIL %s busy: got %h want %h", tag, busy, model_busy_vec());
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || wrr !== '0 || wrdata !== '0 || busy !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got en=%b a=%0d d=%h busy=%h, want all zero",
               wr_en, wrr, wrdata, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    rsv_valid = 1; rsv_addr = 5;
    step("reserve5");
    rsv_valid = 0;
    n_checks++;
    if (busy[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_set: got %b want 1", busy[5]);
    end
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    step("single");
    req0_valid = 0;
    n_checks++;
    if (wr_en !== 1'b1 || wrr !== 5'd5 || wrdata !== 32'hDEADBEEF || busy[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: got en=%b a=%0d d=%h busy5=%b, want 1 5 deadbeef 0",
               wr_en, wrr, wrdata, busy[5]);
    end
  endtask

  // Assert reset in the middle of a cycle while the write port is active and
  // REQ0 is valid. The outputs must clear without waiting for a clock edge.
  task automatic test_async_reset();
    rsv_valid = 1; rsv_addr = 9;
    req1_valid = 1; req1_addr = 3; req1_data = 32'h1234_5678;
    step("pre_async");
    idle_inputs();
    req0_valid = 1; req0_addr = 4; req0_data = 32'hCAFE_F00D;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || wrr !== '0 || wrdata !== '0 || busy !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b a=%0d d=%h busy=%h, want all zero",
               wr_en, wrr, wrdata, busy);
    end
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_contention();
    int got [4];
`ifdef RISCV_RFARB_RR_EN
    int exp_seq [4] = '{0, 1, 0, 1};
`else
    int exp_seq [4] = '{1, 1, 1, 1};
`endif
    apply_reset();
    req0_valid = 1; req0_addr = 1; req0_data = 32'hA0A0_0001;
    req1_valid = 1; req1_addr = 2; req1_data = 32'hB1B1_0002;
    for (int i = 0; i < 4; i++) begin
      step("contention");
      got[i] = last_grant;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] != exp_seq[i]) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: got grant %0d want %0d", i, got[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_x0_hold();
    logic [AW-1:0] a_before;
    logic [BW-1:0] d_before;
    req1_valid = 1; req1_addr = 0; req1_data = 32'h0BAD_0BAD;
    step("x0");
    n_checks++;
    if (wr_en !== 1'b0 || last_grant != 1) begin
      n_fail++;
      $display("FAIL x0_write: got en=%b grant=%0d want en=0 grant=1", wr_en, last_grant);
    end
    a_before = wrr; d_before = wrdata;
    wp_hold = 1;
    req0_valid = 1; req0_addr = 6; req0_data = 32'h6666_6666;
    req1_valid = 1; req1_addr = 8; req1_data = 32'h8888_8888;
    step("hold");
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || wr_en !== 1'b0 ||
        wrr !== a_before || wrdata !== d_before) begin
      n_fail++;
      $display("FAIL hold: got r0=%b r1=%b en=%b a=%0d d=%h, want 0 0 0 %0d %h",
               req0_ready, req1_ready, wr_en, wrr, wrdata, a_before, d_before);
    end
    idle_inputs();
  endtask

  task automatic test_rsv_collision();
    rsv_valid = 1; rsv_addr = 7;
    step("rsv7");
    req0_valid = 1; req0_addr = 7; req0_data = 32'h7777_0007;
    step("collision");
    idle_inputs();
    n_checks++;
    if (busy[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL rsv_collision: got busy7=%b want 1", busy[7]);
    end
  endtask

  task automatic test_rsv_x0();
    rsv_valid = 1; rsv_addr = 0;
    step("rsv_x0");
    idle_inputs();
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rsv_x0: got busy0=%b want 0", busy[0]);
    end
  endtask

  // Random traffic that obeys the handshake: a pending request keeps its
  // address and data until it is granted.
  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid && $urandom_range(0, 3) != 0) begin
        req0_valid = 1; req0_addr = AW'($urandom); req0_data = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1; req1_addr = AW'($urandom); req1_data = $urandom;
      end
      wp_hold   = ($urandom_range(0, 9) == 0);
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_addr  = AW'($urandom);
      step("random");
      if (last_grant == 0) req0_valid = 0;
      if (last_grant == 1) req1_valid = 0;
    end
    idle_inputs();
  endtask

  initial begin
    last_grant = -1;
    idle_inputs();
    model_reset();
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_async_reset();
    test_contention();
    test_x0_hold();
    test_rsv_collision();
    test_rsv_x0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_rf_wr_arbiter.md
# riscv_rf_wr_arbiter

Write-port arbiter and register scoreboard for the RISC-V integer register file. It shares the file's single write port between two writeback requesters: requester 0 is ALU/execute writeback, requester 1 is load/memory writeback. Each cycle it grants at most one request, and drives the registered write port (enable, address, data) into the register file one cycle after acceptance. It also keeps a per-register busy bit, set by decode reservations and cleared on writeback, which the hazard logic uses to stall.

## Interface
- BUS_WIDTH, 32, data width of the write port.
- REG_ADDR_WIDTH, 5, register address width.
- REG_DEPTH, 1<<REG_ADDR_WIDTH, number of registers and width of the busy vector.

- i_CLK  in  1  clock; all state updates on the rising edge.
- i_RST_N  in  1  reset; asynchronous, active-low.
- i_REQ0_VALID  in  1  requester 0 has a write pending.
- i_REQ0_ADDR  in  REG_ADDR_WIDTH  requester 0 destination register.
- i_REQ0_DATA  in  BUS_WIDTH  requester 0 write data.
- o_REQ0_READY  out  1  requester 0 granted this cycle.
- i_REQ1_VALID / i_REQ1_ADDR / i_REQ1_DATA / o_REQ1_READY  same as requester 0, for requester 1.
- i_WP_HOLD  in  1  blocks all grants this cycle (used for debug access to the register file).
- i_RSV_VALID  in  1  decode reserves a destination register.
- i_RSV_ADDR  in  REG_ADDR_WIDTH  register being reserved.
- o_WREnable  out  1  write enable to the register file.
- o_WRR  out  REG_ADDR_WIDTH  write address to the register file.
- o_WRDATA  out  BUS_WIDTH  write data to the register file.
- o_BUSY  out  REG_DEPTH  scoreboard; bit n set means register n has a write outstanding.

## Operation
- **Handshake.** A request transfers at a rising edge when VALID and READY are both 1.
  - Requesters hold ADDR and DATA stable while VALID=1 and READY=0.
  - A requester may not drop VALID before the transfer.
- **Grant.** READY is combinational from the VALIDs, i_WP_HOLD and the priority pointer.
  - At most one READY is high in any cycle.
  - READY is never high while i_WP_HOLD=1 or while its own VALID=0.
- **Priority.** The pointer register gives the favoured requester when both are valid; the other requester waits. The pointer's update rule is set in Configuration.
- **Write port.** The registered outputs load on a transfer:
  - o_WRR and o_WRDATA take the granted ADDR and DATA.
  - o_WREnable=1, except when the granted ADDR is 0: the x0 write is still accepted (READY=1) but o_WREnable=0.
  - With no transfer, o_WREnable=0 and o_WRR/o_WRDATA hold their previous values.
- **Scoreboard.**
  - A transfer with ADDR≠0 clears busy[ADDR].
  - i_RSV_VALID with i_RSV_ADDR≠0 sets busy[i_RSV_ADDR].
  - If the same register is set and cleared at the same edge, set wins.
  - busy[0] is constant 0.
- **Same address from both requesters.** Both may present the same ADDR; they are serialised in arbitration order with no merging. Write ordering is the upstream's responsibility.
- **Reset.** Asynchronous assertion forces:
  - o_WREnable=0, o_WRR=0, o_WRDATA=0;
  - o_BUSY=0;
  - pointer favours requester 0.
  
  A pending request is lost on reset; the requester re-presents it after reset is released.

## Timing
- Request accepted at edge N → o_WREnable/o_WRR/o_WRDATA valid during cycle N+1. Because the register file writes combinationally, its read ports return the new value in cycle N+1.
- The busy bit clears at edge N, so o_BUSY is low from cycle N+1, the same cycle the data is visible.
- Sustained throughput: one write per cycle. Each requester is guaranteed service within 2 cycles when round-robin is enabled.
- The only combinational input→output paths are VALID / i_WP_HOLD → READY. o_BUSY and the write port are registered.
- Reset deassertion is synchronised by the system reset controller, not by this block.

## Configuration
- Macro: RISCV_RFARB_RR_EN.
- Defined: round-robin priority. After every transfer the pointer moves to favour the requester that was not granted. With no transfer the pointer holds.
- Undefined: fixed priority. Requester 1 (load) always wins, and the pointer register is removed. Requester 0 can starve under continuous load traffic; this is accepted in the in-order single-issue configuration.

## Test plan
- **Reset.** Drive i_RST_N low mid-cycle with REQ0 valid → o_WREnable=0, o_WRR=0, o_BUSY=0 immediately, without waiting for an edge.
- **Single write.** REQ0 ADDR=5, DATA=0xDEADBEEF, i_RSV previously set busy[5] → READY0=1 in cycle N; in cycle N+1 o_WREnable=1, o_WRR=5, o_WRDATA=0xDEADBEEF, busy[5]=0.
- **Contention.** Both requesters valid for 4 cycles (ADDR 1 and 2), macro defined → grants alternate 0,1,0,1. Macro undefined → requester 1 is granted all 4 cycles.
- **x0 and hold.**
  - REQ1 ADDR=0 → READY1=1, o_WREnable=0 next cycle.
  - i_WP_HOLD=1 with both valid → both READY=0, outputs hold.
- **Reserve/release collision.** i_RSV_ADDR=7 and a writeback to 7 at the same edge → busy[7]=1 afterwards.
- **Reserve x0.** i_RSV_ADDR=0 → busy[0] stays 0.
